// File: rtl/rebeccargb_tt09ball_screensaver.sv
// VGA 640x480@60 bouncing-ball screensaver (TinyTapeout user block).
// Draws a 32x32 filled circle on black. The ball moves once per frame
// during vblank, bounces off the edges and changes colour on each bounce.
module rebeccargb_tt09ball_screensaver (
  input  logic       clk,
  input  logic       rst_n,   // active-high despite the name (harness compatibility)
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam logic [9:0]         H_LAST  = 10'd799;
  localparam logic [9:0]         V_LAST  = 10'd524;
  localparam logic [9:0]         H_VIS   = 10'd640;
  localparam logic [9:0]         V_VIS   = 10'd480;
  localparam logic [9:0]         HS_BEG  = 10'd656;
  localparam logic [9:0]         HS_END  = 10'd751;
  localparam logic [9:0]         VS_BEG  = 10'd490;
  localparam logic [9:0]         VS_END  = 10'd491;
  localparam logic signed [11:0] X_LIM   = 12'sd608;
  localparam logic signed [11:0] Y_LIM   = 12'sd448;
  localparam logic [5:0]         WHITE   = 6'b111111;

  logic [9:0] hcount, vcount;
  logic [9:0] bx;
  logic [8:0] by;
  logic       dirx, diry;
  logic [5:0] col;

  logic unused;
  assign unused = &{1'b0, ena, uio_in, ui_in[6:2]};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Colour cycle: white, red, yellow, green, cyan, blue, magenta, white.
  function automatic logic [5:0] next_col(input logic [5:0] c);
    case (c)
      6'b111111: next_col = 6'b110000;
      6'b110000: next_col = 6'b111100;
      6'b111100: next_col = 6'b001100;
      6'b001100: next_col = 6'b001111;
      6'b001111: next_col = 6'b000011;
      6'b000011: next_col = 6'b110011;
      6'b110011: next_col = 6'b111111;
      default:   next_col = WHITE;
    endcase
  endfunction

  // Raster counters; vcount is only written on the line wrap.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // Motion: one update per frame at the first vblank line, unless paused.
  logic              upd;
  logic [2:0]        spd3;
  logic signed [11:0] spd, nx, ny;
  logic [9:0]        nx_c;
  logic [8:0]        ny_c;
  logic              ndx, ndy, hitx, hity;

  assign upd  = (hcount == 10'd0) && (vcount == V_VIS) && !ui_in[7];
  assign spd3 = {1'b0, ui_in[1:0]} + 3'd1;
  assign spd  = $signed({9'd0, spd3});

  // Next position and direction with edge clamping.
  always_comb begin
    nx   = dirx ? ($signed({2'b00, bx}) + spd) : ($signed({2'b00, bx}) - spd);
    ny   = diry ? ($signed({3'b000, by}) + spd) : ($signed({3'b000, by}) - spd);
    nx_c = nx[9:0];
    ndx  = dirx;
    hitx = 1'b0;
    ny_c = ny[8:0];
    ndy  = diry;
    hity = 1'b0;
    if (nx >= X_LIM) begin
      nx_c = 10'd608; ndx = 1'b0; hitx = 1'b1;
    end else if (nx <= 12'sd0) begin
      nx_c = 10'd0;   ndx = 1'b1; hitx = 1'b1;
    end
    if (ny >= Y_LIM) begin
      ny_c = 9'd448;  ndy = 1'b0; hity = 1'b1;
    end else if (ny <= 12'sd0) begin
      ny_c = 9'd0;    ndy = 1'b1; hity = 1'b1;
    end
  end

  // Ball state register; a corner hit advances the colour only once.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      bx   <= 10'd304;
      by   <= 9'd224;
      dirx <= 1'b1;
      diry <= 1'b1;
      col  <= WHITE;
    end else if (upd) begin
      bx   <= nx_c;
      by   <= ny_c;
      dirx <= ndx;
      diry <= ndy;
      if (hitx || hity) col <= next_col(col);
    end
  end

  // Pixel test. |2u-31| for u in 0..31 is {u[4] ? u[3:0] : ~u[3:0], 1}.
  logic [11:0] ux, uy;
  logic [4:0]  ma, mb;
  logic [9:0]  a_sq, b_sq;
  logic [10:0] r2;
  logic        in_box, visible, ball, hs, vs;
  logic [5:0]  pix;

  assign ux      = {2'b00, hcount} - {2'b00, bx};
  assign uy      = {2'b00, vcount} - {3'b000, by};
  assign in_box  = (ux[11:5] == 7'd0) && (uy[11:5] == 7'd0);
  assign ma      = {ux[4] ? ux[3:0] : ~ux[3:0], 1'b1};
  assign mb      = {uy[4] ? uy[3:0] : ~uy[3:0], 1'b1};
  assign a_sq    = {5'd0, ma} * {5'd0, ma};
  assign b_sq    = {5'd0, mb} * {5'd0, mb};
  assign r2      = {1'b0, a_sq} + {1'b0, b_sq};
  assign ball    = in_box && (r2 <= 11'd1024);
  assign visible = (hcount < H_VIS) && (vcount < V_VIS);
  assign pix     = (visible && ball) ? col : 6'd0;
  assign hs      = !((hcount >= HS_BEG) && (hcount <= HS_END));
  assign vs      = !((vcount >= VS_BEG) && (vcount <= VS_END));

  // Registered TinyVGA output: {HS,B0,G0,R0,VS,B1,G1,R1}.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) uo_out <= 8'h88;
    else       uo_out <= {hs, pix[0], pix[2], pix[4], vs, pix[1], pix[3], pix[5]};
  end
endmodule

// File: tb/tb_rebeccargb_tt09ball_screensaver.sv
// Scoreboard bench for the bouncing-ball screensaver. Expectations are keyed
// by raster position (h,v) that the registered output reflects; a monitor
// pops and compares them on the falling clock edge. Long stretches of the
// frame are skipped by briefly forcing the line counter or the ball position
// mid-frame, where the design never writes those registers.
module tb_rebeccargb_tt09ball_screensaver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  rebeccargb_tt09ball_screensaver dut (
    .clk(clk), .rst_n(rst), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #20 clk = ~clk;

  typedef struct {
    string      name;
    int         h;      // -1: check at the next falling edge
    int         v;
    int         sel;    // 0 uo_out, 1 uio_out, 2 uio_oe
    logic [7:0] mask;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   th = 0, tv = 0, ph = 0, pv = 0;
  bit   pvalid = 1'b0;
  int   total = 0, bad = 0, tmo = 0;
  bit   done = 1'b0, fin = 1'b0;
  logic [9:0] fv;
  logic [9:0] fx;
  logic [8:0] fy;
  exp_t       e;
  logic [7:0] act;

  // Monitor: compare the head of the queue when its position comes round.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].h < 0 || (pvalid && q[0].h == ph && q[0].v == pv)) begin
        e   = q.pop_front();
        act = (e.sel == 1) ? uio_out : (e.sel == 2) ? uio_oe : uo_out;
        total++;
        if ((act & e.mask) != e.val) begin
          bad++;
          $display("FAIL %s: got %02h want %02h (mask %02h)", e.name, act & e.mask, e.val, e.mask);
        end
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      total++;
      if (tmo != 0) begin
        bad++;
        $display("FAIL timeouts: got %0d want 0", tmo);
      end
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL unchecked: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #8000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string n, input int h, input int v, input logic [7:0] val,
                     input logic [7:0] mask = 8'hFF);
    q.push_back('{n, h, v, 0, mask, val});
  endtask

  task automatic chk_now(input string n, input int sel, input logic [7:0] val);
    q.push_back('{n, -1, 0, sel, 8'hFF, val});
  endtask

  // One clock; track the raster position the next output will reflect.
  task automatic tick();
    @(posedge clk);
    if (rst) pvalid = 1'b0;
    else begin
      ph = th; pv = tv; pvalid = 1'b1;
      if (th == 799) begin
        th = 0;
        tv = (tv == 524) ? 0 : tv + 1;
      end else th = th + 1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int h, input int v, input string n);
    int k = 0;
    while (!(th == h && tv == v) && k < 3000) begin
      tick();
      k++;
    end
    if (!(th == h && tv == v)) begin
      tmo++;
      $display("FAIL %s: reached (%0d,%0d) want (%0d,%0d)", n, th, tv, h, v);
    end
  endtask

  task automatic drain(input string n);
    int k = 0;
    while (q.size() > 0 && k < 4000) begin
      tick();
      k++;
    end
    if (q.size() > 0) begin
      tmo++;
      $display("FAIL %s: got %0d pending want 0", n, q.size());
    end
  endtask

  // Skip ahead so that the next full line is L.
  task goto_line(input int L);
    run_to(700, (th <= 700) ? tv : ((tv == 524) ? 0 : tv + 1), "goto");
    fv = 10'(L - 1);
    force dut.vcount = fv;
    tv = L - 1;
    tick();
    tick();
    release dut.vcount;
  endtask

  task pass_update();
    goto_line(480);
    run_to(5, 480, "update");
  endtask

  initial begin
    ena = 1'b1; uio_in = 8'h00; ui_in = 8'h80;
    #5 rst = 1'b1;
    chk_now("rst_uo", 0, 8'h88);
    chk_now("rst_uio_out", 1, 8'h00);
    chk_now("rst_uio_oe", 2, 8'h00);
    drain("rst");
    rst = 1'b0; th = 0; tv = 0;

    // Syncs after release
    chk("first_cycle", 0, 0, 8'h88);
    chk("vs_line0", 300, 0, 8'h08, 8'h08);
    chk("hs_pre", 655, 0, 8'h80, 8'h80);
    chk("hs_fall", 656, 0, 8'h00, 8'h80);
    chk("hs_last", 751, 0, 8'h00, 8'h80);
    chk("hs_rise", 752, 0, 8'h80, 8'h80);
    chk("hs_pre1", 655, 1, 8'h80, 8'h80);
    chk("hs_fall1", 656, 1, 8'h00, 8'h80);
    drain("hsync");

    // Static ball at reset position (paused)
    goto_line(100);
    chk("black_100", 100, 100, 8'h88);
    drain("l100");
    goto_line(224);
    chk("corner", 304, 224, 8'h88);
    chk("near_corner", 305, 224, 8'h88);
    chk("top_mid", 320, 224, 8'hFF);
    drain("l224");
    goto_line(240);
    chk("left_out", 303, 240, 8'h88);
    chk("left_edge", 304, 240, 8'hFF);
    chk("centre", 320, 240, 8'hFF);
    chk("right_out", 336, 240, 8'h88);
    drain("l240");
    goto_line(255);
    chk("bot_mid", 320, 255, 8'hFF);
    chk("bot_corner", 335, 255, 8'h88);
    drain("l255");

    // VSYNC
    goto_line(489);
    chk("vs_pre", 799, 489, 8'h08, 8'h08);
    chk("vs_fall", 0, 490, 8'h00, 8'h08);
    chk("vs_last", 799, 491, 8'h00, 8'h08);
    chk("vs_rise", 0, 492, 8'h08, 8'h08);
    drain("vsync");

    // Speed 4: (304,224) -> (308,228)
    ui_in = 8'h03;
    pass_update();
    goto_line(224);
    chk("moved_old_top", 320, 224, 8'h88);
    drain("m224");
    goto_line(227);
    chk("moved_above", 324, 227, 8'h88);
    chk("moved_top", 324, 228, 8'hFF);
    drain("m227");
    goto_line(244);
    chk("moved_lout", 307, 244, 8'h88);
    chk("moved_ledge", 308, 244, 8'hFF);
    chk("moved_redge", 339, 244, 8'hFF);
    chk("moved_rout", 340, 244, 8'h88);
    drain("m244");

    // Right-edge bounce: 604+4 -> 608, dirx=0, red
    fx = 10'd604;
    force dut.bx = fx;
    tick();
    release dut.bx;
    pass_update();
    goto_line(232);
    chk("bx_corner", 608, 232, 8'h88);
    drain("b232");
    goto_line(248);
    chk("bx_ledge", 608, 248, 8'h99);
    chk("bx_centre", 624, 248, 8'h99);
    chk("bx_redge", 639, 248, 8'h99);
    drain("b248");

    // Moves left after bounce: (604,236), still red
    pass_update();
    goto_line(252);
    chk("left_lout", 603, 252, 8'h88);
    chk("left_ledge", 604, 252, 8'h99);
    chk("left_centre", 620, 252, 8'h99);
    chk("left_rout", 636, 252, 8'h88);
    drain("l252");

    // Corner bounce on both axes: colour advances once (red -> yellow)
    fx = 10'd2;
    fy = 9'd446;
    force dut.bx = fx;
    force dut.by = fy;
    tick();
    release dut.bx;
    release dut.by;
    pass_update();
    goto_line(447);
    chk("cb_above", 16, 447, 8'h88);
    chk("cb_top", 16, 448, 8'hBB);
    drain("c447");
    goto_line(464);
    chk("cb_ledge", 0, 464, 8'hBB);
    chk("cb_centre", 16, 464, 8'hBB);
    chk("cb_rout", 32, 464, 8'h88);
    drain("c464");

    // Pause for three updates
    ui_in = 8'h83;
    repeat (3) pass_update();
    goto_line(447);
    chk("p_above", 16, 447, 8'h88);
    chk("p_top", 16, 448, 8'hBB);
    drain("p447");
    goto_line(464);
    chk("p_ledge", 0, 464, 8'hBB);
    chk("p_rout", 32, 464, 8'h88);
    drain("p464");

    // Resume at speed 2: (0,448) -> (2,446)
    ui_in = 8'h01;
    pass_update();
    goto_line(445);
    chk("r_above", 18, 445, 8'h88);
    chk("r_top", 18, 446, 8'hBB);
    drain("r445");
    goto_line(462);
    chk("r_lout", 1, 462, 8'h88);
    chk("r_ledge", 2, 462, 8'hBB);
    drain("r462");

    // Asynchronous reset mid-frame while HSYNC is low
    goto_line(100);
    chk("mid_hs_low", 699, 100, 8'h00, 8'h80);
    run_to(700, 100, "mid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    pvalid = 1'b0;
    chk_now("async_rst", 0, 8'h88);
    drain("async");
    tick();
    rst = 1'b0; th = 0; tv = 0;
    chk("re_first", 0, 0, 8'h88);
    chk("re_hs_pre", 655, 0, 8'h80, 8'h80);
    chk("re_hs_fall", 656, 0, 8'h00, 8'h80);
    drain("re_hs");
    goto_line(224);
    chk("re_corner", 304, 224, 8'h88);
    chk("re_top", 320, 224, 8'hFF);
    drain("re224");
    goto_line(240);
    chk("re_centre", 320, 240, 8'hFF);
    drain("re240");
    goto_line(446);
    chk("re_old_pos", 18, 446, 8'h88);
    drain("re446");

    done = 1'b1;
  end
endmodule
